// File: rtl/clahe_pkg.sv
// Shared constants and FSM encodings for the CLAHE clip / CDF stage.
package clahe_pkg;

  localparam int NUM_TILES   = 16;
  localparam int BINS        = 256;
  localparam int CNT_W       = 16;
  localparam int TILE_PIXELS = 57600;
  localparam int SCALE       = 74271;

  localparam int ACC_W  = 24;
  localparam int PROD_W = 41;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CLIP  = 3'd1;
  localparam logic [2:0] ST_DRAIN = 3'd2;
  localparam logic [2:0] ST_CALC  = 3'd3;
  localparam logic [2:0] ST_CDF   = 3'd4;
  localparam logic [2:0] ST_NEXT  = 3'd5;

endpackage

// File: rtl/clahe_cdf_map.sv
// CDF accumulator followed by scale / round / saturate to an 8-bit grey level.
// The LUT write strobe, address and data leave one cycle after the addend.
module clahe_cdf_map #(
  parameter int BIN_W       = 8,
  parameter int TILE_PIXELS = clahe_pkg::TILE_PIXELS,
  parameter int SCALE       = clahe_pkg::SCALE
) (
  input  logic                          pclk,
  input  logic                          rst,
  input  logic                          clr,
  input  logic                          vld_p0,
  input  logic [clahe_pkg::ACC_W-1:0]   add_p0,
  input  logic [BIN_W-1:0]              addr_p0,
  output logic                          wr_en,
  output logic [BIN_W-1:0]              wr_addr,
  output logic [7:0]                    wr_data
);
  import clahe_pkg::*;

  localparam logic [PROD_W-1:0] ROUND = PROD_W'(1) << 23;

  logic [ACC_W-1:0] cdf_p1;
  logic [ACC_W-1:0] cdf_nxt;

  function automatic logic [ACC_W-1:0] acc_sat(input logic [ACC_W-1:0] a,
                                               input logic [ACC_W-1:0] b);
    logic [ACC_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[ACC_W] ? '1 : s[ACC_W-1:0];
  endfunction

  function automatic logic [7:0] map_sat(input logic [ACC_W-1:0] c);
    logic [PROD_W-1:0] p;
    p = PROD_W'(c) * PROD_W'(SCALE) + ROUND;
    if ((c >= ACC_W'(TILE_PIXELS)) || (|p[PROD_W-1:32]))
      return 8'hff;
    return p[31:24];
  endfunction

  assign cdf_nxt = acc_sat(cdf_p1, add_p0);

  // p0 -> p1: accumulate, map and present the LUT write
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      cdf_p1  <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= vld_p0;
      if (clr) begin
        cdf_p1 <= '0;
      end else if (vld_p0) begin
        cdf_p1  <= cdf_nxt;
        wr_addr <= addr_p0;
        wr_data <= map_sat(cdf_nxt);
      end
    end
  end

endmodule

// File: rtl/clahe_clip_cdf.sv
// Per-tile clip, excess redistribution and CDF-to-LUT generation over one
// completed histogram bank. Tiles are processed in order, 515 cycles each.
module clahe_clip_cdf #(
  parameter int NUM_TILES   = clahe_pkg::NUM_TILES,
  parameter int BINS        = clahe_pkg::BINS,
  parameter int CNT_W       = clahe_pkg::CNT_W,
  parameter int TILE_PIXELS = clahe_pkg::TILE_PIXELS,
  parameter int SCALE       = clahe_pkg::SCALE
) (
  input  logic                         pclk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         ping_pong_flag,
  input  logic [CNT_W-1:0]             clip_limit,
  output logic                         hist_rd_bank,
  output logic [$clog2(NUM_TILES)-1:0] hist_rd_tile_idx,
  output logic [$clog2(BINS)-1:0]      hist_rd_addr,
  input  logic [CNT_W-1:0]             hist_rd_data,
  output logic [$clog2(NUM_TILES)-1:0] lut_wr_tile_idx,
  output logic [$clog2(BINS)-1:0]      lut_wr_addr,
  output logic [7:0]                   lut_wr_data,
  output logic                         lut_wr_en,
  output logic                         busy,
  output logic                         done
);
  import clahe_pkg::*;

  localparam int TILE_W = $clog2(NUM_TILES);
  localparam int BIN_W  = $clog2(BINS);
  localparam int INC_W  = ACC_W - BIN_W;
  localparam logic [TILE_W-1:0] TILE_LAST = TILE_W'(NUM_TILES - 1);
  localparam logic [BIN_W-1:0]  BIN_LAST  = BIN_W'(BINS - 1);

  logic [2:0]        state;
  logic [TILE_W-1:0] tile;
  logic [BIN_W-1:0]  bin;
  logic              bank;
  logic [CNT_W-1:0]  clip;
  logic [ACC_W-1:0]  excess;
  logic [INC_W-1:0]  inc;
  logic [BIN_W-1:0]  resid;
  logic              vld_p0;
  logic [BIN_W-1:0]  bin_p0;
  logic [CNT_W-1:0]  hbuf [BINS];
  logic [ACC_W-1:0]  cdf_add;
  logic              cdf_clr;
  logic              cdf_vld;

  function automatic logic [CNT_W-1:0] clip_bin(input logic [CNT_W-1:0] h,
                                                input logic [CNT_W-1:0] c);
    return (h > c) ? c : h;
  endfunction

  function automatic logic [ACC_W-1:0] excess_acc(input logic [ACC_W-1:0] acc,
                                                  input logic [CNT_W-1:0] h,
                                                  input logic [CNT_W-1:0] c);
    logic [ACC_W:0] s;
    s = {1'b0, acc} + ((h > c) ? (ACC_W+1)'(h - c) : '0);
    return s[ACC_W] ? '1 : s[ACC_W-1:0];
  endfunction

  assign hist_rd_bank     = bank;
  assign hist_rd_tile_idx = tile;
  assign hist_rd_addr     = bin;
  assign lut_wr_tile_idx  = tile;
  assign busy             = (state != ST_IDLE);
  assign cdf_clr          = (state == ST_CALC);
  assign cdf_vld          = (state == ST_CDF);
  assign cdf_add          = ACC_W'(hbuf[bin]) + ACC_W'(inc) + ACC_W'(bin < resid);

  // Control: bin walk, tile sequencing, excess accumulation (read data at p0)
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      tile   <= '0;
      bin    <= '0;
      bank   <= 1'b0;
      clip   <= '0;
      excess <= '0;
      inc    <= '0;
      resid  <= '0;
      vld_p0 <= 1'b0;
      done   <= 1'b0;
    end else begin
      done   <= 1'b0;
      vld_p0 <= (state == ST_CLIP);
      if (vld_p0)
        excess <= excess_acc(excess, hist_rd_data, clip);
      case (state)
        ST_IDLE: begin
          if (start) begin
            clip   <= clip_limit;
            bank   <= ping_pong_flag;
            tile   <= '0;
            bin    <= '0;
            excess <= '0;
            state  <= ST_CLIP;
          end
        end
        ST_CLIP: begin
          bin <= bin + 1'b1;
          if (bin == BIN_LAST)
            state <= ST_DRAIN;
        end
        ST_DRAIN: state <= ST_CALC;
        ST_CALC: begin
          inc   <= excess[ACC_W-1:BIN_W];
          resid <= excess[BIN_W-1:0];
          bin   <= '0;
          state <= ST_CDF;
        end
        ST_CDF: begin
          bin <= bin + 1'b1;
          if (bin == BIN_LAST)
            state <= ST_NEXT;
        end
        ST_NEXT: begin
          if (tile == TILE_LAST) begin
            done  <= 1'b1;
            state <= ST_IDLE;
          end else begin
            tile   <= tile + 1'b1;
            bin    <= '0;
            excess <= '0;
            state  <= ST_CLIP;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // p0: clipped bin capture into the tile buffer
  always_ff @(posedge pclk) begin
    bin_p0 <= bin;
    if (vld_p0)
      hbuf[bin_p0] <= clip_bin(hist_rd_data, clip);
  end

  clahe_cdf_map #(
    .BIN_W       (BIN_W),
    .TILE_PIXELS (TILE_PIXELS),
    .SCALE       (SCALE)
  ) u_cdf_map (
    .pclk    (pclk),
    .rst     (rst),
    .clr     (cdf_clr),
    .vld_p0  (cdf_vld),
    .add_p0  (cdf_add),
    .addr_p0 (bin),
    .wr_en   (lut_wr_en),
    .wr_addr (lut_wr_addr),
    .wr_data (lut_wr_data)
  );

endmodule

// File: tb/tb_clahe_clip_cdf.sv
// Bench for clahe_clip_cdf: histogram RAM model, LUT capture, a frame-level
// reference model and a per-cycle compare process.
module tb_clahe_clip_cdf;

  localparam int NT     = 16;
  localparam int NB     = 256;
  localparam int SCL    = 74271;
  localparam int T_TILE = 515;
  localparam int T_DONE = NT * T_TILE + 1;

  logic        pclk = 1'b0;
  logic        rst;
  logic        start;
  logic        ping_pong_flag;
  logic [15:0] clip_limit;
  logic        hist_rd_bank;
  logic [3:0]  hist_rd_tile_idx;
  logic [7:0]  hist_rd_addr;
  logic [15:0] hist_rd_data = '0;
  logic [3:0]  lut_wr_tile_idx;
  logic [7:0]  lut_wr_addr;
  logic [7:0]  lut_wr_data;
  logic        lut_wr_en;
  logic        busy;
  logic        done;

  always #5 pclk = ~pclk;

  clahe_clip_cdf dut (
    .pclk             (pclk),
    .rst              (rst),
    .start            (start),
    .ping_pong_flag   (ping_pong_flag),
    .clip_limit       (clip_limit),
    .hist_rd_bank     (hist_rd_bank),
    .hist_rd_tile_idx (hist_rd_tile_idx),
    .hist_rd_addr     (hist_rd_addr),
    .hist_rd_data     (hist_rd_data),
    .lut_wr_tile_idx  (lut_wr_tile_idx),
    .lut_wr_addr      (lut_wr_addr),
    .lut_wr_data      (lut_wr_data),
    .lut_wr_en        (lut_wr_en),
    .busy             (busy),
    .done             (done)
  );

  logic [15:0] hist    [2][NT][NB];
  logic [7:0]  lut_mem [NT][NB];
  int          exp_lut [NT][NB];
  int          m_inc [NT];
  int          m_resid [NT];
  int          m_step100 [NT];

  int unsigned cyc = 0;
  int n_cmp = 0;
  int n_err = 0;
  int e0 = 0;
  int go_cnt = 0;
  bit exp_bank = 1'b0;
  int done_cnt = 0;

  // histogram RAM (1-cycle read) and LUT RAM
  always @(posedge pclk) begin
    cyc <= cyc + 1;
    hist_rd_data <= hist[hist_rd_bank][hist_rd_tile_idx][hist_rd_addr];
    if (lut_wr_en)
      lut_mem[lut_wr_tile_idx][lut_wr_addr] <= lut_wr_data;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] outs_or();
    return 64'({hist_rd_bank, hist_rd_tile_idx, hist_rd_addr, lut_wr_tile_idx,
                lut_wr_addr, lut_wr_data, lut_wr_en, busy, done});
  endfunction

  // Reference: clip, spread excess, cumulative sum, scale to 0..255
  task automatic model_frame(input int b, input int clip);
    longint ex, cdf, prev, mp;
    int h, c, inc, resid;
    for (int t = 0; t < NT; t++) begin
      ex = 0;
      for (int i = 0; i < NB; i++) begin
        h = int'(hist[b][t][i]);
        if (h > clip) ex += h - clip;
      end
      inc   = int'(ex / NB);
      resid = int'(ex % NB);
      m_inc[t]   = inc;
      m_resid[t] = resid;
      cdf  = 0;
      prev = 0;
      for (int i = 0; i < NB; i++) begin
        h = int'(hist[b][t][i]);
        c = (h < clip) ? h : clip;
        cdf += c + inc + ((i < resid) ? 1 : 0);
        mp = (cdf * SCL + 64'd8388608) / 64'd16777216;
        exp_lut[t][i] = (mp > 255) ? 255 : int'(mp);
        if (i == 100) m_step100[t] = int'(cdf - prev);
        prev = cdf;
      end
    end
  endtask

  // Compare process: frame timing, bank, every LUT write, idle quietness
  int  mon_e0 = 0;
  int  last_go = 0;
  int  wr_cnt = 0;
  bit  mon_bank = 1'b0;
  bit  mon_active = 1'b0;
  always @(negedge pclk) begin
    int lab, t, i;
    if (rst) begin
      chk("outs_in_reset", outs_or(), 64'd0);
      mon_active = 1'b0;
    end else begin
      lab = int'(cyc) - mon_e0 + 1;
      if (mon_active && lab >= 1) begin
        chk("busy", 64'(busy), 64'(lab < T_DONE));
        chk("rd_bank", 64'(hist_rd_bank), 64'(mon_bank));
        if (lut_wr_en) begin
          chk("wr_in_range", 64'(wr_cnt < NT * NB), 64'd1);
          t = (wr_cnt / NB) % NT;
          i = wr_cnt % NB;
          chk("wr_tile", 64'(lut_wr_tile_idx), 64'(t));
          chk("wr_addr", 64'(lut_wr_addr), 64'(i));
          chk("wr_data", 64'(lut_wr_data), 64'(exp_lut[t][i]));
          chk("wr_cycle", 64'(lab), 64'(T_TILE * t + 260 + i));
          wr_cnt++;
        end
        if (done) begin
          chk("done_cycle", 64'(lab), 64'(T_DONE));
          chk("wr_total", 64'(wr_cnt), 64'(NT * NB));
          done_cnt++;
          mon_active = 1'b0;
        end else if (lab > T_DONE) begin
          chk("done_late", 64'(lab), 64'(T_DONE));
          mon_active = 1'b0;
        end
      end else if (!mon_active) begin
        chk("idle_quiet", 64'({done, lut_wr_en}), 64'd0);
      end
      if (go_cnt != last_go) begin
        last_go    = go_cnt;
        mon_e0     = e0;
        mon_bank   = exp_bank;
        wr_cnt     = 0;
        mon_active = 1'b1;
      end
    end
  end

  task automatic start_frame(input bit pp, input int clip);
    model_frame(int'(pp), clip);
    ping_pong_flag = pp;
    clip_limit     = 16'(clip);
    start          = 1'b1;
    e0             = int'(cyc) + 1;
    exp_bank       = pp;
    go_cnt++;
    @(negedge pclk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < T_DONE + 50; k++) begin
      @(negedge pclk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    chk("done_seen", 64'(ok), 64'd1);
  endtask

  task automatic fill_const(input int b, input int t, input int v);
    for (int i = 0; i < NB; i++) hist[b][t][i] = 16'(v);
  endtask

  task automatic fill_sum(input int b, input int t);
    int r [NB];
    for (int i = 0; i < NB; i++) r[i] = int'($urandom_range(0, 225));
    for (int i = 0; i < NB; i++) hist[b][t][i] = 16'(225 + r[i] - r[(i + 1) % NB]);
  endtask

  task automatic fill_rand(input int b, input int t, input int maxv);
    for (int i = 0; i < NB; i++) hist[b][t][i] = 16'($urandom_range(0, maxv));
  endtask

  task automatic uniform_lits(input int t, input string tag);
    chk({tag, "_lut0"},   64'(lut_mem[t][0]),   64'd1);
    chk({tag, "_lut127"}, 64'(lut_mem[t][127]), 64'd127);
    chk({tag, "_lut255"}, 64'(lut_mem[t][255]), 64'd255);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    ping_pong_flag = 1'b0;
    clip_limit = '0;
    for (int b = 0; b < 2; b++)
      for (int t = 0; t < NT; t++) fill_const(b, t, 0);
    repeat (3) @(negedge pclk);
    chk("reset_outs", outs_or(), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge pclk);

    // Frame A: uniform 225, clip 400; stray start at cycle 100 must be ignored
    for (int t = 0; t < NT; t++) fill_const(0, t, 225);
    start_frame(1'b0, 400);
    chk("modelA_inc", 64'(m_inc[0]), 64'd0);
    chk("modelA_lut127", 64'(exp_lut[0][127]), 64'd127);
    repeat (99) @(negedge pclk);
    ping_pong_flag = 1'b1;
    clip_limit = 16'd0;
    start = 1'b1;
    @(negedge pclk);
    start = 1'b0;
    ping_pong_flag = 1'b0;
    clip_limit = 16'd400;
    wait_done();
    uniform_lits(0, "A_t0");
    uniform_lits(7, "A_t7");
    uniform_lits(15, "A_t15");
    repeat (5) @(negedge pclk);

    // Frame B: spike in tile 0, random shapes elsewhere, clip 1000, bank 1
    fill_const(1, 0, 0);
    hist[1][0][100] = 16'd57600;
    for (int t = 1; t < NT; t++) fill_sum(1, t);
    start_frame(1'b1, 1000);
    chk("modelB_inc", 64'(m_inc[0]), 64'd221);
    chk("modelB_resid", 64'(m_resid[0]), 64'd24);
    chk("modelB_step100", 64'(m_step100[0]), 64'd1221);
    chk("modelB_lut0", 64'(exp_lut[0][0]), 64'd1);
    for (int t = 0; t < NT; t++) fill_sum(0, t);
    wait_done();
    chk("B_lut0", 64'(lut_mem[0][0]), 64'd1);
    chk("B_lut255", 64'(lut_mem[0][255]), 64'd255);

    // Frame C: back-to-back in the done cycle, bank flips, clip 0
    start_frame(1'b0, 0);
    wait_done();
    uniform_lits(3, "C_t3");
    uniform_lits(12, "C_t12");
    repeat (4) @(negedge pclk);

    // Frame D: full-range counts, aborted by reset mid-CDF of tile 5
    for (int t = 0; t < NT; t++) fill_rand(1, t, 65535);
    start_frame(1'b1, int'($urandom_range(0, 65535)));
    repeat (T_TILE * 5 + 259 + 50 - 1) @(negedge pclk);
    chk("busy_before_abort", 64'(busy), 64'd1);
    #2 rst = 1'b1;
    #1 chk("rst_async_outs", outs_or(), 64'd0);
    repeat (3) @(negedge pclk);
    rst = 1'b0;
    repeat (3) @(negedge pclk);

    // Frame E: restart from tile 0 on bank 0, mixed saturating / normal tiles
    for (int t = 0; t < NT; t++) begin
      if (t % 2 == 0) fill_rand(0, t, 65535);
      else fill_rand(0, t, 450);
    end
    start_frame(1'b0, int'($urandom_range(0, 600)));
    wait_done();
    repeat (5) @(negedge pclk);
    chk("done_count", 64'(done_cnt), 64'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
